// File: rtl/response_router_pkg.sv
// Shared definitions for the response return path.
// Contents:
//   ID_WIDTH / DATA_WIDTH  - response field widths used by shared_resource
//   CHANNEL_SEL_BIT        - id bit that selects the return channel
//   RESPONSE_WIDTH         - width of one buffered {data, id} entry
//   channel_e              - channel selector encoding (id MSB)
package response_router_pkg;

    localparam int ID_WIDTH        = 4;
    localparam int DATA_WIDTH      = 8;
    localparam int CHANNEL_SEL_BIT = ID_WIDTH - 1;
    localparam int RESPONSE_WIDTH  = DATA_WIDTH + ID_WIDTH;

    typedef enum logic {
        CH1 = 1'b0,
        CH2 = 1'b1
    } channel_e;

endpackage

// File: rtl/response_fifo.sv
// Per-channel response buffer. The head entry is driven straight from
// storage, so a push becomes visible one cycle later and never bypasses.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   push, push_data     - write an entry (ignored when full unless popping)
//   pop                 - consume the head entry (ignored when empty)
//   head_data           - head entry, zero while empty
//   head_valid          - FIFO holds at least one entry
//   full                - count == DEPTH
//   count               - occupancy, 0..DEPTH
module response_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       head_valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok, push_ok;

    assign head_valid = (count_q != '0);
    assign full       = (count_q == CW'(DEPTH));
    assign count      = count_q;
    // Zero the head while empty so outputs read 0 after reset.
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;

    assign pop_ok  = pop & head_valid;
    // A full FIFO still accepts a push when the head leaves the same edge.
    assign push_ok = push & (~full | pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; emptiness is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/response_router.sv
// Steers the shared resource's response stream to one of two return
// channels by id MSB, buffering each channel in its own FIFO.
// Ports:
//   clk, reset                          - clock, asynchronous active-low reset
//   in_data, in_id, in_valid            - response stream (no backpressure)
//   out_ready                           - both FIFOs have >= SLACK free entries
//   out_data_x, out_id_x, out_valid_x   - channel x head entry
//   in_stall_x                          - channel x downstream stall
//   out_overflow_x                      - sticky: a channel x response was dropped
//   out_drop_count                      - saturating count of dropped responses
module response_router
    import response_router_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int SLACK     = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic                  in_valid,
    output logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data_1,
    output logic [ID_WIDTH-1:0]   out_id_1,
    output logic                  out_valid_1,
    input  logic                  in_stall_1,
    output logic [DATA_WIDTH-1:0] out_data_2,
    output logic [ID_WIDTH-1:0]   out_id_2,
    output logic                  out_valid_2,
    input  logic                  in_stall_2,
    output logic                  out_overflow_1,
    output logic                  out_overflow_2,
    output logic [CNT_WIDTH-1:0]  out_drop_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    channel_e                sel;
    logic                    push_1, push_2, pop_1, pop_2;
    logic                    full_1, full_2, drop_1, drop_2;
    logic [CW-1:0]           count_1, count_2, cnt_next_1, cnt_next_2;
    logic [RESPONSE_WIDTH-1:0] head_1, head_2;

    logic                    ready_q, ready_d;
    logic                    ovf_1_q, ovf_1_d, ovf_2_q, ovf_2_d;
    logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;

    assign sel    = channel_e'(in_id[CHANNEL_SEL_BIT]);
    assign push_1 = in_valid & (sel == CH1);
    assign push_2 = in_valid & (sel == CH2);
    assign pop_1  = out_valid_1 & ~in_stall_1;
    assign pop_2  = out_valid_2 & ~in_stall_2;

    response_fifo #(.WIDTH(RESPONSE_WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
        .clk        (clk),
        .reset      (reset),
        .push       (push_1),
        .push_data  ({in_data, in_id}),
        .pop        (pop_1),
        .head_data  (head_1),
        .head_valid (out_valid_1),
        .full       (full_1),
        .count      (count_1)
    );

    response_fifo #(.WIDTH(RESPONSE_WIDTH), .DEPTH(DEPTH)) u_fifo_2 (
        .clk        (clk),
        .reset      (reset),
        .push       (push_2),
        .push_data  ({in_data, in_id}),
        .pop        (pop_2),
        .head_data  (head_2),
        .head_valid (out_valid_2),
        .full       (full_2),
        .count      (count_2)
    );

    assign {out_data_1, out_id_1} = head_1;
    assign {out_data_2, out_id_2} = head_2;

    // Mirrors the FIFOs' accept rule so out_ready can be registered from
    // next-state occupancy without exposing extra FIFO ports.
    assign drop_1 = push_1 & full_1 & ~pop_1;
    assign drop_2 = push_2 & full_2 & ~pop_2;

    always_comb begin
        cnt_next_1 = count_1 + CW'(push_1 & ~drop_1) - CW'(pop_1);
        cnt_next_2 = count_2 + CW'(push_2 & ~drop_2) - CW'(pop_2);
        ready_d    = ((CW'(DEPTH) - cnt_next_1) >= CW'(SLACK)) &&
                     ((CW'(DEPTH) - cnt_next_2) >= CW'(SLACK));
        ovf_1_d    = ovf_1_q | drop_1;
        ovf_2_d    = ovf_2_q | drop_2;
        // At most one response arrives per cycle, so at most one drop.
        drop_cnt_d = (drop_1 | drop_2) ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q    <= 1'b1;
            ovf_1_q    <= 1'b0;
            ovf_2_q    <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ready_q    <= ready_d;
            ovf_1_q    <= ovf_1_d;
            ovf_2_q    <= ovf_2_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_ready      = ready_q;
    assign out_overflow_1 = ovf_1_q;
    assign out_overflow_2 = ovf_2_q;
    assign out_drop_count = drop_cnt_q;

endmodule

// File: doc/response_router.md
Name: response_router

Overview:
- Return-path block sitting between shared_resource and the two request pipelines.
- Takes the resource's response stream (data, id, valid) and steers each response back to its originating channel, selected by the id MSB.
- Buffers responses per channel, exposes pipeline-style valid/stall outputs and gives the resource/arbiter a ready signal so responses are not lost.
- Replaces the single consumer endpoint when per-channel returns are required.

Parameters:
- DEPTH, 4, entries per channel FIFO (power of two, >= 2).
- SLACK, 2, free entries required in BOTH FIFOs for out_ready to be high; covers resource pipeline latency.
- CNT_WIDTH, 8, width of saturating drop counter.

Ports:
- clk  input  1  single clock, all state rising-edge.
- reset  input  1  asynchronous, active-low; one clock, and reset is asynchronous and active-low.
- in_data  input  `DATA_WIDTH  response data from shared_resource.
- in_id  input  `ID_WIDTH  response id; bit `ID_WIDTH-1 selects channel (0 -> channel 1, 1 -> channel 2).
- in_valid  input  1  response present this cycle; no backpressure on this interface.
- out_ready  output  1  high when both FIFOs have >= SLACK free entries; ANDed into arbiter grant upstream.
- out_data_1  output  `DATA_WIDTH  channel 1 head data.
- out_id_1  output  `ID_WIDTH  channel 1 head id.
- out_valid_1  output  1  channel 1 head valid.
- in_stall_1  input  1  channel 1 downstream stall.
- out_data_2 / out_id_2 / out_valid_2 / in_stall_2: same as channel 1 for channel 2.
- out_overflow_1  output  1  sticky: a channel 1 response was dropped.
- out_overflow_2  output  1  sticky: a channel 2 response was dropped.
- out_drop_count  output  CNT_WIDTH  total dropped responses, saturating.

Behaviour:
- Reset (asserted low, async): both FIFOs empty (pointers and counts 0), out_valid_1/2 = 0, out_data/out_id = 0, out_ready = 1, overflow flags = 0, drop count = 0.
- Deassertion is sampled synchronously. Reset mid-operation discards all buffered responses.
- Push: when in_valid=1, the entry {in_data, in_id} is written into the FIFO selected by in_id MSB at the rising edge.
- Latency: a response accepted at edge N is visible on out_valid_x/out_data_x/out_id_x after edge N. This is one cycle; there is no combinational in->out path.
- Output: head of FIFO driven from storage. out_valid_x = (count_x != 0).
- Pop: at an edge where out_valid_x=1 and in_stall_x=0, the head is consumed.
- While stalled, out_data_x/out_id_x are held stable.
- Full: count_x == DEPTH.
  - A push with a simultaneous pop is accepted; count is unchanged and pointers advance.
  - A push without a pop is dropped. Set out_overflow_x (sticky until reset) and increment out_drop_count, saturating at all-ones.
- Empty: a pop is impossible (out_valid_x=0). A push into an empty FIFO appears next cycle; there is no same-cycle bypass.
- Pointers wrap modulo DEPTH. count_x ranges 0..DEPTH and needs $clog2(DEPTH)+1 bits.
- out_ready is registered from next-state counts: high when (DEPTH - count_1_next) >= SLACK and (DEPTH - count_2_next) >= SLACK.
- Channels are independent: a stall on channel 1 never blocks channel 2 pops. Only out_ready couples them.
- Only one response can arrive per cycle, so there is never a simultaneous push to both FIFOs.

Decomposition:
- Shared defines.vh already holds ADDRESS_WIDTH, ID_WIDTH, DATA_WIDTH. Add:
  - CHANNEL_SEL_BIT = `ID_WIDTH-1.
  - RESPONSE_WIDTH = `DATA_WIDTH+`ID_WIDTH.
- One sub-module, response_fifo (params WIDTH, DEPTH):
  - ports push/push_data, pop, head_data/head_valid, full, count.
  - Instantiated twice.
- Drop accounting and out_ready live in response_router.

Test Plan:
- Reset then idle -> out_ready=1, out_valid_1=out_valid_2=0, drop count 0. Asserting reset low mid-traffic clears all valids asynchronously.
- in_valid for one cycle with in_id=0x03 (MSB 0), data 0xA5 -> next cycle out_valid_1=1, out_data_1=0xA5, out_id_1=0x03; out_valid_2=0. Popped in the same cycle if in_stall_1=0.
- in_stall_2=1, push 4 responses with id MSB=1 (DEPTH=4) -> out_ready falls after the 3rd push (count 3, free 1 < SLACK). The 5th push is dropped: out_overflow_2=1, drop count=1, head is still the 1st entry.
- Channel 2 full and stalled; release stall in the same cycle as a channel 2 push -> push accepted, count stays 4, order preserved 2,3,4,5.
- Interleaved ids 1,2,1,2 with in_stall_1 toggling every cycle -> each channel delivers its responses in order with no loss. Channel 2 throughput is unaffected by channel 1 stall.
- 260 drops with CNT_WIDTH=8 -> out_drop_count saturates at 0xFF.
